// File: rtl/clock_pkg.sv
// Shared types and constants for the clock setting controller.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

  // Encoding is exported on the mode output, so keep values stable.
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    ALM_HR  = 3'd3,
    ALM_MIN = 3'd4
  } state_e;

  // Hour increment with 23 -> 0 wrap.
  function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] h);
    return (h >= MAX_HOUR) ? '0 : h + HOUR_W'(1);
  endfunction

  // Minute increment with 59 -> 0 wrap.
  function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] m);
    return (m >= MAX_MIN) ? '0 : m + MIN_W'(1);
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Counts tick pulses while enabled; flags the tick that reaches LIMIT.
// Disabling or clearing returns the count to zero.
module idle_timer #(
  parameter int unsigned LIMIT = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q;

  // expire_o is the terminal tick itself, so the owner acts on the same edge.
  assign expire_o = en_i && !clr_i && tick_i && (count_q == LAST);

  // Tick counter; restarts after expiry, on clear, or while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (!en_i || clr_i || expire_o) begin
      count_q <= '0;
    end else if (tick_i) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven time/alarm setting controller with alarm ring detection.
// Next-state logic is computed in one combinational block; every output
// comes straight from a register.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 30,
  parameter int unsigned RING_S    = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sec_pulse,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [HOUR_W-1:0] cur_hours,
  input  logic [MIN_W-1:0]  cur_minutes,
  input  logic [SEC_W-1:0]  cur_seconds,
  output logic              load,
  output logic [HOUR_W-1:0] load_hours,
  output logic [MIN_W-1:0]  load_minutes,
  output logic [HOUR_W-1:0] disp_hours,
  output logic [MIN_W-1:0]  disp_minutes,
  output logic [2:0]        mode,
  output logic              blink,
  output logic              alarm_en,
  output logic              alarm_ring
);

  state_e            state_q, state_d;
  logic [HOUR_W-1:0] edit_h_q, edit_h_d;
  logic [MIN_W-1:0]  edit_m_q, edit_m_d;
  logic [HOUR_W-1:0] alarm_h_q, alarm_h_d;
  logic [MIN_W-1:0]  alarm_m_q, alarm_m_d;
  logic              alarm_en_q, alarm_en_d;
  logic              alarm_ring_q, alarm_ring_d;
  logic              match_prev_q;
  logic              blink_q, blink_d;
  logic              load_q, load_d;
  logic [HOUR_W-1:0] load_h_q, load_h_d;
  logic [MIN_W-1:0]  load_m_q, load_m_d;
  logic [HOUR_W-1:0] disp_h_q, disp_h_d;
  logic [MIN_W-1:0]  disp_m_q, disp_m_d;

  logic btn_any;
  logic idle_expire;
  logic ring_expire;
  logic alarm_match;

  assign btn_any = btn_mode | btn_inc;

  // Seconds without a press, only counted while editing.
  idle_timer #(.LIMIT(TIMEOUT_S)) u_idle (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q != RUN),
    .clr_i    (btn_any),
    .tick_i   (sec_pulse),
    .expire_o (idle_expire)
  );

  // Seconds spent ringing, for the self-clear.
  idle_timer #(.LIMIT(RING_S)) u_ring (
    .clk      (clk),
    .reset    (reset),
    .en_i     (alarm_ring_q),
    .clr_i    (1'b0),
    .tick_i   (sec_pulse),
    .expire_o (ring_expire)
  );

  assign alarm_match = alarm_en_q && (cur_hours == alarm_h_q) &&
                       (cur_minutes == alarm_m_q) && (cur_seconds == '0);

  // Next-state and next-output computation.
  always_comb begin
    state_d      = state_q;
    edit_h_d     = edit_h_q;
    edit_m_d     = edit_m_q;
    alarm_h_d    = alarm_h_q;
    alarm_m_d    = alarm_m_q;
    alarm_en_d   = alarm_en_q;
    alarm_ring_d = alarm_ring_q;
    load_d       = 1'b0;
    load_h_d     = load_h_q;
    load_m_d     = load_m_q;
    blink_d      = blink_q;

    if (alarm_ring_q && btn_any) begin
      // A press while ringing only silences the alarm.
      alarm_ring_d = 1'b0;
    end else if (btn_mode) begin
      // Mode has priority over a simultaneous increment.
      case (state_q)
        RUN: begin
          state_d  = SET_HR;
          edit_h_d = cur_hours;
          edit_m_d = cur_minutes;
        end
        SET_HR:  state_d = SET_MIN;
        SET_MIN: begin
          load_d   = 1'b1;
          load_h_d = edit_h_q;
          load_m_d = edit_m_q;
          state_d  = ALM_HR;
          edit_h_d = alarm_h_q;
          edit_m_d = alarm_m_q;
        end
        ALM_HR:  state_d = ALM_MIN;
        ALM_MIN: begin
          alarm_h_d  = edit_h_q;
          alarm_m_d  = edit_m_q;
          alarm_en_d = 1'b1;
          state_d    = RUN;
        end
        default: state_d = RUN;
      endcase
    end else if (btn_inc) begin
      case (state_q)
        RUN:             alarm_en_d = ~alarm_en_q;
        SET_HR, ALM_HR:  edit_h_d   = inc_hour(edit_h_q);
        SET_MIN, ALM_MIN: edit_m_d  = inc_min(edit_m_q);
        default:         state_d    = RUN;
      endcase
    end else if (idle_expire) begin
      // Abandon the edit: nothing is loaded or written.
      state_d = RUN;
    end

    if (alarm_ring_q && ring_expire) begin
      alarm_ring_d = 1'b0;
    end
    if (alarm_match && !match_prev_q) begin
      alarm_ring_d = 1'b1;
    end

    if (state_d == RUN) begin
      blink_d = 1'b0;
    end else if (state_d != state_q) begin
      blink_d = 1'b1;
    end else if (sec_pulse) begin
      blink_d = ~blink_q;
    end

    disp_h_d = (state_d == RUN) ? cur_hours   : edit_h_d;
    disp_m_d = (state_d == RUN) ? cur_minutes : edit_m_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      edit_h_q     <= '0;
      edit_m_q     <= '0;
      alarm_h_q    <= '0;
      alarm_m_q    <= '0;
      alarm_en_q   <= 1'b0;
      alarm_ring_q <= 1'b0;
      match_prev_q <= 1'b0;
      blink_q      <= 1'b0;
      load_q       <= 1'b0;
      load_h_q     <= '0;
      load_m_q     <= '0;
      disp_h_q     <= '0;
      disp_m_q     <= '0;
    end else begin
      state_q      <= state_d;
      edit_h_q     <= edit_h_d;
      edit_m_q     <= edit_m_d;
      alarm_h_q    <= alarm_h_d;
      alarm_m_q    <= alarm_m_d;
      alarm_en_q   <= alarm_en_d;
      alarm_ring_q <= alarm_ring_d;
      match_prev_q <= alarm_match;
      blink_q      <= blink_d;
      load_q       <= load_d;
      load_h_q     <= load_h_d;
      load_m_q     <= load_m_d;
      disp_h_q     <= disp_h_d;
      disp_m_q     <= disp_m_d;
    end
  end

  assign mode         = state_q;
  assign load         = load_q;
  assign load_hours   = load_h_q;
  assign load_minutes = load_m_q;
  assign disp_hours   = disp_h_q;
  assign disp_minutes = disp_m_q;
  assign blink        = blink_q;
  assign alarm_en     = alarm_en_q;
  assign alarm_ring   = alarm_ring_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: table of button vectors plus
// hand-written sequences for wrap, timeout, reset and alarm behaviour.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_pulse, btn_mode, btn_inc;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes, cur_seconds;
  logic       load;
  logic [4:0] load_hours, disp_hours;
  logic [5:0] load_minutes, disp_minutes;
  logic [2:0] mode;
  logic       blink, alarm_en, alarm_ring;

  clock_set_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .sec_pulse    (sec_pulse),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .cur_hours    (cur_hours),
    .cur_minutes  (cur_minutes),
    .cur_seconds  (cur_seconds),
    .load         (load),
    .load_hours   (load_hours),
    .load_minutes (load_minutes),
    .disp_hours   (disp_hours),
    .disp_minutes (disp_minutes),
    .mode         (mode),
    .blink        (blink),
    .alarm_en     (alarm_en),
    .alarm_ring   (alarm_ring)
  );

  always #5 clk = ~clk;

  typedef enum int {F_MODE, F_LOAD, F_LH, F_LM, F_DH, F_DM, F_BLINK, F_AEN, F_RING, F_LCNT} field_e;
  typedef struct {
    string       tag;
    field_e      f;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    bit         m;
    bit         i;
    logic [2:0] mode;
    bit         load;
    logic [4:0] lh;
    logic [5:0] lm;
    logic [4:0] dh;
    logic [5:0] dm;
    bit         aen;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   load_count = 0;
  vec_t tbl[14];

  // Independent count of load pulses seen on the output.
  always @(negedge clk) if (load === 1'b1) load_count++;

  task automatic push(input string tag, input field_e f, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.f   = f;
    e.val = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] field_val(input field_e f);
    case (f)
      F_MODE:  return 32'(mode);
      F_LOAD:  return 32'(load);
      F_LH:    return 32'(load_hours);
      F_LM:    return 32'(load_minutes);
      F_DH:    return 32'(disp_hours);
      F_DM:    return 32'(disp_minutes);
      F_BLINK: return 32'(blink);
      F_AEN:   return 32'(alarm_en);
      F_RING:  return 32'(alarm_ring);
      default: return 32'(load_count);
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [31:0] act;
    while (sb.size() != 0) begin
      e   = sb.pop_front();
      act = field_val(e.f);
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d", e.tag, act, e.val);
      end else begin
        $display("ok   %s = %0d", e.tag, act);
      end
    end
  endtask

  // One clock cycle of stimulus, entered and left on a falling edge.
  task automatic cyc(input logic m, input logic i, input logic sp);
    btn_mode  = m;
    btn_inc   = i;
    sec_pulse = sp;
    @(negedge clk);
    btn_mode  = 1'b0;
    btn_inc   = 1'b0;
    sec_pulse = 1'b0;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hours   = 5'(h);
    cur_minutes = 6'(m);
    cur_seconds = 6'(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          m  i  mode ld lh  lm  dh  dm  aen
    tbl[0]  = '{0, 0, 3'd0, 0, 0,  0,  10, 20, 0};
    tbl[1]  = '{1, 0, 3'd1, 0, 0,  0,  10, 20, 0};
    tbl[2]  = '{0, 1, 3'd1, 0, 0,  0,  11, 20, 0};
    tbl[3]  = '{0, 1, 3'd1, 0, 0,  0,  12, 20, 0};
    tbl[4]  = '{1, 0, 3'd2, 0, 0,  0,  12, 20, 0};
    tbl[5]  = '{0, 1, 3'd2, 0, 0,  0,  12, 21, 0};
    tbl[6]  = '{1, 0, 3'd3, 1, 12, 21, 0,  0,  0};
    tbl[7]  = '{0, 0, 3'd3, 0, 12, 21, 0,  0,  0};
    tbl[8]  = '{0, 1, 3'd3, 0, 12, 21, 1,  0,  0};
    tbl[9]  = '{1, 0, 3'd4, 0, 12, 21, 1,  0,  0};
    tbl[10] = '{0, 1, 3'd4, 0, 12, 21, 1,  1,  0};
    tbl[11] = '{1, 0, 3'd0, 0, 12, 21, 10, 20, 1};
    tbl[12] = '{0, 1, 3'd0, 0, 12, 21, 10, 20, 0};
    tbl[13] = '{0, 1, 3'd0, 0, 12, 21, 10, 20, 1};

    reset = 1'b1;
    sec_pulse = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    set_cur(10, 20, 5);
    @(negedge clk);
    @(negedge clk);
    push("rst.mode", F_MODE, 0);  push("rst.load", F_LOAD, 0);
    push("rst.lh", F_LH, 0);      push("rst.lm", F_LM, 0);
    push("rst.blink", F_BLINK, 0); push("rst.aen", F_AEN, 0);
    push("rst.ring", F_RING, 0);
    drain();
    reset = 1'b0;

    // Table: full edit walk from 10:20, load of 12:21, alarm edit, alarm_en toggles.
    for (int k = 0; k < 14; k++) begin
      push($sformatf("vec%0d.mode", k), F_MODE, 32'(tbl[k].mode));
      push($sformatf("vec%0d.load", k), F_LOAD, 32'(tbl[k].load));
      push($sformatf("vec%0d.lh", k), F_LH, 32'(tbl[k].lh));
      push($sformatf("vec%0d.lm", k), F_LM, 32'(tbl[k].lm));
      push($sformatf("vec%0d.dh", k), F_DH, 32'(tbl[k].dh));
      push($sformatf("vec%0d.dm", k), F_DM, 32'(tbl[k].dm));
      push($sformatf("vec%0d.aen", k), F_AEN, 32'(tbl[k].aen));
      push($sformatf("vec%0d.blink", k), F_BLINK, (tbl[k].mode != 3'd0) ? 32'd1 : 32'd0);
      cyc(tbl[k].m, tbl[k].i, 1'b0);
      drain();
    end

    // Wraps at 23 and 59, then timeout from SET_MIN.
    set_cur(23, 59, 5);
    push("wrap.mode_hr", F_MODE, 1); push("wrap.dh23", F_DH, 23); push("wrap.blink", F_BLINK, 1);
    cyc(1, 0, 0); drain();
    push("wrap.h_to0", F_DH, 0);
    cyc(0, 1, 0); drain();
    push("wrap.mode_min", F_MODE, 2); push("wrap.dm59", F_DM, 59);
    cyc(1, 0, 0); drain();
    push("wrap.m_to0", F_DM, 0); push("wrap.h_kept", F_DH, 0);
    cyc(0, 1, 0); drain();
    for (int p = 1; p <= 30; p++) begin
      if (p == 1)  push("tmo.blink_tog0", F_BLINK, 0);
      if (p == 2)  push("tmo.blink_tog1", F_BLINK, 1);
      if (p == 29) push("tmo.still_min", F_MODE, 2);
      if (p == 30) begin
        push("tmo.run", F_MODE, 0); push("tmo.dh", F_DH, 23);
        push("tmo.dm", F_DM, 59);   push("tmo.blink", F_BLINK, 0);
        push("tmo.noload", F_LOAD, 0);
      end
      cyc(0, 0, 1); drain();
    end
    cyc(0, 0, 0);
    push("tmo.load_count", F_LCNT, 1);
    drain();

    // Simultaneous mode+inc in SET_HR, then reset mid-edit.
    set_cur(8, 15, 0);
    push("both.hr", F_MODE, 1); push("both.dh", F_DH, 8);
    cyc(1, 0, 0); drain();
    push("both.min", F_MODE, 2); push("both.dh_kept", F_DH, 8); push("both.dm", F_DM, 15);
    cyc(1, 1, 0); drain();
    reset = 1'b1;
    #1;
    push("mrst.mode", F_MODE, 0); push("mrst.load", F_LOAD, 0);
    push("mrst.lh", F_LH, 0);     push("mrst.lm", F_LM, 0);
    push("mrst.dh", F_DH, 0);     push("mrst.dm", F_DM, 0);
    push("mrst.blink", F_BLINK, 0); push("mrst.aen", F_AEN, 0);
    push("mrst.ring", F_RING, 0);
    drain();
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 0); cyc(0, 0, 0);
    push("mrst.load_count", F_LCNT, 1); push("mrst.run", F_MODE, 0);
    drain();

    // Program alarm 06:30 through the full mode cycle.
    set_cur(5, 0, 10);
    cyc(1, 0, 0); cyc(1, 0, 0);
    push("alm.load", F_LOAD, 1); push("alm.lh", F_LH, 5); push("alm.lm", F_LM, 0);
    push("alm.mode", F_MODE, 3); push("alm.dh", F_DH, 0);
    cyc(1, 0, 0); drain();
    for (int k = 0; k < 6; k++) cyc(0, 1, 0);
    push("alm.dh6", F_DH, 6);
    drain();
    push("alm.min", F_MODE, 4);
    cyc(1, 0, 0); drain();
    for (int k = 0; k < 30; k++) cyc(0, 1, 0);
    push("alm.dm30", F_DM, 30);
    drain();
    push("alm.run", F_MODE, 0); push("alm.aen", F_AEN, 1);
    push("alm.disp_cur_h", F_DH, 5); push("alm.disp_cur_m", F_DM, 0);
    cyc(1, 0, 0); drain();

    // Ring on match, silence with a press, no retrigger within the minute.
    set_cur(6, 29, 59);
    push("ring.before", F_RING, 0);
    cyc(0, 0, 0); drain();
    set_cur(6, 30, 0);
    push("ring.set", F_RING, 1);
    cyc(0, 0, 0); drain();
    push("ring.cleared", F_RING, 0); push("ring.aen_kept", F_AEN, 1); push("ring.mode", F_MODE, 0);
    cyc(0, 1, 0); drain();
    for (int k = 0; k < 3; k++) begin
      push($sformatf("ring.noretrig%0d", k), F_RING, 0);
      cyc(0, 0, 0); drain();
    end

    // Self-clear after RING_S seconds.
    set_cur(6, 30, 1);
    cyc(0, 0, 0);
    set_cur(6, 30, 0);
    push("ring.set2", F_RING, 1);
    cyc(0, 0, 0); drain();
    for (int p = 1; p <= 60; p++) begin
      if (p == 59) push("ring.hold59", F_RING, 1);
      if (p == 60) push("ring.self_clear", F_RING, 0);
      cyc(0, 0, 1); drain();
    end
    cyc(0, 0, 0);
    push("end.load_count", F_LCNT, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_S, default 30: sec_pulse count with no button press before an edit is abandoned.
REQ-002 SHALL have parameter RING_S, default 60: sec_pulse count after which an unacknowledged alarm self-clears.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sec_pulse  input  1  one-cycle 1 Hz tick from the clock divider.
REQ-006 SHALL have port btn_mode  input  1  one-cycle debounced mode press.
REQ-007 SHALL have port btn_inc  input  1  one-cycle debounced increment press.
REQ-008 SHALL have ports cur_hours  input  5, cur_minutes  input  6, cur_seconds  input  6  binary time from the timekeeper.
REQ-009 SHALL have port load  output  1  one-cycle strobe: timekeeper loads load_hours/load_minutes and clears seconds.
REQ-010 SHALL have ports load_hours  output  5, load_minutes  output  6  values to load.
REQ-011 SHALL have ports disp_hours  output  5, disp_minutes  output  6  values to display.
REQ-012 SHALL have port mode  output  3  current state encoding.
REQ-013 SHALL have ports blink  output  1  blanks the edited field; alarm_en  output  1; alarm_ring  output  1.

Function
REQ-014 SHALL implement states RUN, SET_HR, SET_MIN, ALM_HR, ALM_MIN; all outputs registered; each transition occurs on the clock edge that samples the button, visible the next cycle.
REQ-015 RUN + btn_mode SHALL go to SET_HR and capture edit_h<=cur_hours, edit_m<=cur_minutes.
REQ-016 RUN + btn_inc SHALL toggle alarm_en.
REQ-017 SET_HR/ALM_HR + btn_inc SHALL increment edit_h, wrapping 23->0; SET_MIN/ALM_MIN + btn_inc SHALL increment edit_m, wrapping 59->0.
REQ-018 SET_HR + btn_mode -> SET_MIN; ALM_HR + btn_mode -> ALM_MIN.
REQ-019 SET_MIN + btn_mode SHALL pulse load for exactly 1 cycle with load_hours=edit_h, load_minutes=edit_m, then go to ALM_HR with edit_h/edit_m loaded from alarm_h/alarm_m.
REQ-020 ALM_MIN + btn_mode SHALL write alarm_h<=edit_h, alarm_m<=edit_m, set alarm_en=1, and go to RUN.
REQ-021 btn_mode and btn_inc in the same cycle: btn_mode SHALL win; btn_inc is ignored.
REQ-022 In any non-RUN state, the idle count SHALL increment on sec_pulse, clear on any button, and on reaching TIMEOUT_S return to RUN with no load and no alarm write (edits discarded).
REQ-023 disp_* SHALL equal cur_* in RUN and edit_* in the other states.
REQ-024 blink SHALL be 0 in RUN, 1 on entry to each set state, and toggle on each sec_pulse while in a set state.
REQ-025 alarm_ring SHALL set in the cycle after cur_hours==alarm_h && cur_minutes==alarm_m && cur_seconds==0 first becomes true with alarm_en=1 (rising-edge match only, once per minute).
REQ-026 While alarm_ring=1, any button press SHALL clear alarm_ring and be consumed with no other effect; alarm_ring SHALL also clear after RING_S sec_pulses.
REQ-027 The alarm SHALL be evaluated in all states; ringing SHALL not alter the edit state.

Reset
REQ-028 Reset SHALL force state=RUN, load=0, load_hours=0, load_minutes=0, edit_h=0, edit_m=0, alarm_h=0, alarm_m=0, alarm_en=0, alarm_ring=0, blink=0, and idle/ring counters=0.
REQ-029 Reset asserted mid-edit SHALL abandon the edit with no load pulse.

Structure
REQ-030 A shared package clock_pkg SHALL hold the state enum, MAX_HOUR=23, MAX_MIN=59 and the field widths.
REQ-031 A sub-module idle_timer (sec_pulse counter with clear and terminal flag) SHALL be used for both the timeout and the ring limit.

Verification
REQ-032 Reset, then cur=10:20, presses mode,inc,inc,mode,inc,mode -> one load pulse with 12:21; state ALM_HR.
REQ-033 In SET_HR with edit_h=23, press inc -> 0; in SET_MIN with edit_m=59, press inc -> 0.
REQ-034 In SET_MIN, no presses for 30 sec_pulses -> RUN, no load, disp follows cur.
REQ-035 Set alarm 06:30, enabled; drive cur 06:30:00 -> alarm_ring=1 next cycle; btn_inc -> ring=0, alarm_en remains 1.
REQ-036 btn_mode and btn_inc pulsed together in SET_HR -> SET_MIN, edit_h unchanged.
REQ-037 Assert reset during SET_MIN -> RUN, load never asserted, all outputs at reset values.
